fifo_rd_ctrl: RTL

Read-domain controller of the async FIFO; the downstream counterpart that consumes the registered gray write pointer from the write-side controller.
- Synchronizes the gray write pointer into r_clk.
- Keeps the binary/gray read pointers and derives the empty flag.
- Drives the synchronous-read memory port.
- Presents data through a 2-entry valid/ready output buffer with full throughput.
- Returns gray_r_ptr, which the write side synchronizes as its sync_rd_ptr.

---
 rtl/fifo_rd_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-domain half of an asynchronous FIFO.
// Synchronizes the write-side gray pointer, owns the read pointer and empty
// flag, drives a synchronous-read memory port and feeds a 2-entry
// valid/ready output buffer that sustains one word per cycle.
// Optional: define FIFO_RD_LEVEL_EN to add the registered rd_level output.
module fifo_rd_ctrl #(
  parameter int P_SIZE      = 4,
  parameter int D_WIDTH     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic               r_clk,
  input  logic               r_rst,
  input  logic [P_SIZE-1:0]  gray_w_ptr,
  output logic               r_en,
  output logic [P_SIZE-2:0]  r_addr,
  input  logic [D_WIDTH-1:0] r_data,
  output logic [P_SIZE-1:0]  gray_r_ptr,
  output logic               empty,
  output logic [D_WIDTH-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [P_SIZE-1:0]  rd_level
`endif
);

  // Synchronizer chain; element SYNC_STAGES-1 is the oldest (output) stage.
  logic [SYNC_STAGES-1:0][P_SIZE-1:0] sync_reg;
  logic [P_SIZE-1:0]                  sync_w_ptr;

  logic [P_SIZE-1:0]       rd_ptr_reg;
  logic [P_SIZE-1:0]       gray_r_ptr_reg;
  logic [P_SIZE-1:0]       comb_gray;
  logic                    inflight_reg;
  logic [1:0][D_WIDTH-1:0] data_reg;
  logic                    head_reg;
  logic                    tail_reg;
  logic [1:0]              count_reg;
  logic [1:0]              count_next;
  logic                    pop;
  logic [2:0]              occ;

  assign sync_w_ptr = sync_reg[SYNC_STAGES-1];
  assign comb_gray  = rd_ptr_reg ^ (rd_ptr_reg >> 1);
  assign empty      = (comb_gray == sync_w_ptr);
  assign r_addr     = rd_ptr_reg[P_SIZE-2:0];
  assign gray_r_ptr = gray_r_ptr_reg;

  assign dout_valid = (count_reg != 2'd0);
  assign dout       = data_reg[head_reg];
  assign pop        = dout_valid && dout_ready;

  // Words that will occupy the buffer after this edge: buffered plus the one
  // arriving from memory, minus the one leaving. Never underflows because a
  // pop requires a buffered word.
  assign occ  = {1'b0, count_reg} + {2'b00, inflight_reg} - {2'b00, pop};
  assign r_en = !empty && (occ < 3'd2);

  // Buffer occupancy update; capture and pop may coincide.
  always_comb begin
    count_next = count_reg + {1'b0, inflight_reg} - {1'b0, pop};
  end

  // Shift the asynchronous gray write pointer through the synchronizer.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], gray_w_ptr};
    end
  end

  // Read pointer advance and registered gray copy for the write domain.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      rd_ptr_reg     <= '0;
      gray_r_ptr_reg <= '0;
      inflight_reg   <= 1'b0;
    end else begin
      gray_r_ptr_reg <= comb_gray;
      inflight_reg   <= r_en;
      if (r_en) begin
        rd_ptr_reg <= rd_ptr_reg + P_SIZE'(1);
      end
    end
  end

  // Two-entry output buffer: memory data lands at the tail, consumer pops the head.
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      data_reg  <= '0;
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      if (inflight_reg) begin
        data_reg[tail_reg] <= r_data;
        tail_reg           <= ~tail_reg;
      end
      if (pop) begin
        head_reg <= ~head_reg;
      end
      count_reg <= count_next;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  // Gray-to-binary of the synchronized write pointer: bit i is the XOR of
  // all gray bits at or above i.
  logic [P_SIZE-1:0] sync_bin;
  logic [P_SIZE-1:0] rd_level_reg;

  for (genvar gi = 0; gi < P_SIZE; gi++) begin : g_gray2bin
    assign sync_bin[gi] = ^sync_w_ptr[P_SIZE-1:gi];
  end

  assign rd_level = rd_level_reg;

  // Words still in memory as seen from the read side (buffer excluded).
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      rd_level_reg <= '0;
    end else begin
      rd_level_reg <= sync_bin - rd_ptr_reg;
    end
  end
`endif

endmodule
